// File: rtl/alu_seq_unit.sv
// alu_seq_unit
//   Handshaked arithmetic/logic unit between the issue stage and write-back.
//   One {op, a, b} transaction is taken on the input valid/ready port. The result
//   is returned, registered, on the output valid/ready port. ADD/SUB/AND/OR/XOR
//   and illegal opcodes complete in one cycle. MUL is an iterative shift-add
//   that takes WIDTH steps.
//
//   Optional feature macro: ALU_FLAGS_EN adds the flag_c/flag_z/flag_v outputs.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous reset, active low
//   in_valid   transaction offered          in_ready   unit accepts this cycle
//   op[2:0]    000 ADD 001 SUB 010 MUL 011 AND 100 OR 101 XOR, 11x illegal
//   a, b       unsigned operands (WIDTH)
//   out_valid  result present               out_ready  consumer takes result
//   out        result, low WIDTH bits       out_err    result from illegal op
//   flag_c/z/v carry/zero/overflow (ALU_FLAGS_EN only)
module alu_seq_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_err
`ifdef ALU_FLAGS_EN
  ,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_v
`endif
);

  localparam int CNTW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t             state;
  logic [CNTW-1:0]    cnt;
  logic [2*WIDTH-1:0] mcand_p1;
  logic [2*WIDTH-1:0] acc_p1;
  logic [WIDTH-1:0]   mplier_p1;
  logic [2*WIDTH-1:0] acc_nxt;
  logic               accept;

  logic [WIDTH-1:0]   sum_c;
  logic [WIDTH-1:0]   dif_c;
  logic [WIDTH-1:0]   res_c;
  logic               err_c;

  // DONE with out_ready set behaves like IDLE so results can stream with no bubble.
  assign in_ready = (state == S_IDLE) | ((state == S_DONE) & out_ready);
  assign accept   = in_valid & in_ready;
  assign acc_nxt  = mplier_p1[0] ? (acc_p1 + mcand_p1) : acc_p1;

  // Stage 0: single-cycle result from the live operands
  always_comb begin
    sum_c = a + b;
    dif_c = a + ~b + {{(WIDTH-1){1'b0}}, 1'b1};
    res_c = '0;
    err_c = 1'b0;
    case (op)
      OP_ADD:  res_c = sum_c;
      OP_SUB:  res_c = dif_c;
      OP_MUL:  res_c = '0;
      OP_AND:  res_c = a & b;
      OP_OR:   res_c = a | b;
      OP_XOR:  res_c = a ^ b;
      default: err_c = 1'b1;
    endcase
  end

`ifdef ALU_FLAGS_EN
  logic c_c;
  logic v_c;

  // Unsigned carry from wrap detection; signed overflow from operand/result sign bits.
  always_comb begin
    c_c = 1'b0;
    v_c = 1'b0;
    case (op)
      OP_ADD: begin
        c_c = (sum_c < a);
        v_c = (a[WIDTH-1] == b[WIDTH-1]) & (sum_c[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        c_c = (a >= b);
        v_c = (a[WIDTH-1] != b[WIDTH-1]) & (dif_c[WIDTH-1] != a[WIDTH-1]);
      end
      default: begin
        c_c = 1'b0;
        v_c = 1'b0;
      end
    endcase
  end
`endif

  // Stage 1: FSM, multiply iteration and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      out       <= '0;
      out_err   <= 1'b0;
      cnt       <= '0;
`ifdef ALU_FLAGS_EN
      flag_c    <= 1'b0;
      flag_z    <= 1'b0;
      flag_v    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if ((state == S_DONE) && out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
          end
          if (accept) begin
            if (op == OP_MUL) begin
              state     <= S_MUL;
              mcand_p1  <= {{WIDTH{1'b0}}, a};
              mplier_p1 <= b;
              acc_p1    <= '0;
              cnt       <= '0;
            end else begin
              state     <= S_DONE;
              out_valid <= 1'b1;
              out       <= res_c;
              out_err   <= err_c;
`ifdef ALU_FLAGS_EN
              flag_c    <= c_c;
              flag_z    <= (res_c == '0);
              flag_v    <= v_c;
`endif
            end
          end
        end
        S_MUL: begin
          acc_p1    <= acc_nxt;
          mcand_p1  <= mcand_p1 << 1;
          mplier_p1 <= mplier_p1 >> 1;
          cnt       <= cnt + CNTW'(1);
          // Last step: publish the freshly accumulated product directly.
          if (cnt == CNTW'(WIDTH - 1)) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
            out       <= acc_nxt[WIDTH-1:0];
            out_err   <= 1'b0;
`ifdef ALU_FLAGS_EN
            flag_c    <= |acc_nxt[2*WIDTH-1:WIDTH];
            flag_z    <= (acc_nxt[WIDTH-1:0] == '0);
            flag_v    <= |acc_nxt[2*WIDTH-1:WIDTH];
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
module tb_alu_seq_unit;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         out_err;
`ifdef ALU_FLAGS_EN
  logic         flag_c;
  logic         flag_z;
  logic         flag_v;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_seq_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_err   (out_err)
`ifdef ALU_FLAGS_EN
    ,
    .flag_c    (flag_c),
    .flag_z    (flag_z),
    .flag_v    (flag_v)
`endif
  );

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] out;
    logic       err;
    logic       c;
    logic       z;
    logic       v;
    int         lat;
  } vec_t;

  typedef struct packed {
    logic       err;
    logic       c;
    logic       z;
    logic       v;
    logic [7:0] res;
  } res_t;

  localparam int NV = 17;
  vec_t tbl [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    op       = o;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Called just after the accept edge; lat counts the accept cycle as cycle 1.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      chk("busy_in_ready", 32'(in_ready), 32'd0);
      tick();
      lat++;
    end
  endtask

  // Reference: results straight from integer arithmetic on the operand values.
  function automatic res_t model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    res_t r;
    int ux, uy, sx, sy, s;
    r  = '0;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    case (o)
      3'd0: begin
        r.res = 8'((ux + uy) % 256);
        r.c   = (ux + uy) > 255;
        s     = sx + sy;
        r.v   = (s > 127) || (s < -128);
      end
      3'd1: begin
        r.res = 8'((ux - uy + 256) % 256);
        r.c   = (ux >= uy);
        s     = sx - sy;
        r.v   = (s > 127) || (s < -128);
      end
      3'd2: begin
        r.res = 8'((ux * uy) % 256);
        r.c   = (ux * uy) > 255;
        r.v   = r.c;
      end
      3'd3: r.res = x & y;
      3'd4: r.res = x | y;
      3'd5: r.res = x ^ y;
      default: r.err = 1'b1;
    endcase
    r.z = (r.res == 8'd0);
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    int   hold;
    logic stale;
    logic [2:0] o;
    logic [7:0] x;
    logic [7:0] y;
    res_t m;

    //          op    a      b      out    err   c     z     v    lat
    tbl[0]  = '{3'd0, 8'd200, 8'd100, 8'd44, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    tbl[1]  = '{3'd1, 8'd5,   8'd7,   8'hFE, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    tbl[2]  = '{3'd2, 8'd13,  8'd11,  8'd143,1'b0, 1'b0, 1'b0, 1'b0, 9};
    tbl[3]  = '{3'd2, 8'd16,  8'd17,  8'h10, 1'b0, 1'b1, 1'b0, 1'b1, 9};
    tbl[4]  = '{3'd3, 8'hF0,  8'h3C,  8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    tbl[5]  = '{3'd4, 8'hF0,  8'h3C,  8'hFC, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    tbl[6]  = '{3'd5, 8'hF0,  8'h3C,  8'hCC, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    tbl[7]  = '{3'd6, 8'hFF,  8'hFF,  8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1};
    tbl[8]  = '{3'd0, 8'd1,   8'd2,   8'd3,  1'b0, 1'b0, 1'b0, 1'b0, 1};
    tbl[9]  = '{3'd0, 8'hFF,  8'h01,  8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1};
    tbl[10] = '{3'd0, 8'h7F,  8'h01,  8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 1};
    tbl[11] = '{3'd1, 8'h80,  8'h01,  8'h7F, 1'b0, 1'b1, 1'b0, 1'b1, 1};
    tbl[12] = '{3'd1, 8'h07,  8'h07,  8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1};
    tbl[13] = '{3'd2, 8'hFF,  8'hFF,  8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 9};
    tbl[14] = '{3'd7, 8'h12,  8'h34,  8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1};
    tbl[15] = '{3'd2, 8'h00,  8'hAB,  8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 9};
    tbl[16] = '{3'd2, 8'h02,  8'h80,  8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 9};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = 3'd0;
    a         = '0;
    b         = '0;
    repeat (3) tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out",       32'(out),       32'd0);
    chk("rst_out_err",   32'(out_err),   32'd0);
    rst_n = 1'b1;
    tick();

    // Table vectors, streamed back to back with out_ready held high.
    for (int i = 0; i < NV; i++) begin
      send(tbl[i].op, tbl[i].a, tbl[i].b);
      wait_out(lat);
      chk($sformatf("v%0d_lat", i), 32'(lat),     32'(tbl[i].lat));
      chk($sformatf("v%0d_out", i), 32'(out),     32'(tbl[i].out));
      chk($sformatf("v%0d_err", i), 32'(out_err), 32'(tbl[i].err));
`ifdef ALU_FLAGS_EN
      chk($sformatf("v%0d_c", i), 32'(flag_c), 32'(tbl[i].c));
      chk($sformatf("v%0d_z", i), 32'(flag_z), 32'(tbl[i].z));
      chk($sformatf("v%0d_v", i), 32'(flag_v), 32'(tbl[i].v));
`endif
    end
    tick();
    chk("drain_valid", 32'(out_valid), 32'd0);

    // Backpressure: result held, input side blocked, offered XOR ignored.
    out_ready = 1'b0;
    send(3'd0, 8'd1, 8'd2);
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid",    32'(out_valid), 32'd1);
      chk("bp_out",      32'(out),       32'd3);
      chk("bp_in_ready", 32'(in_ready),  32'd0);
      op       = 3'd5;
      a        = 8'hAA;
      b        = 8'h55;
      in_valid = 1'b1;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_xfer_valid", 32'(out_valid), 32'd0);
    tick();
    chk("bp_no_extra", 32'(out_valid), 32'd0);

    // Back-to-back XOR then AND with no bubble.
    op       = 3'd5;
    a        = 8'hF0;
    b        = 8'h3C;
    in_valid = 1'b1;
    tick();
    chk("b2b_xor_valid", 32'(out_valid), 32'd1);
    chk("b2b_xor_out",   32'(out),       32'hCC);
    op = 3'd3;
    tick();
    chk("b2b_and_valid", 32'(out_valid), 32'd1);
    chk("b2b_and_out",   32'(out),       32'h30);
    in_valid = 1'b0;
    tick();
    chk("b2b_end_valid", 32'(out_valid), 32'd0);

    // Reset in the middle of a multiply discards it.
    send(3'd2, 8'd13, 8'd11);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_valid",    32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready),  32'd1);
    chk("midrst_out",      32'(out),       32'd0);
    stale = 1'b0;
    repeat (12) begin
      tick();
      if (out_valid) stale = 1'b1;
    end
    chk("midrst_no_stale", 32'(stale), 32'd0);

    // Random transactions against the arithmetic reference, with random backpressure.
    for (int n = 0; n < 200; n++) begin
      o = 3'($urandom_range(0, 7));
      x = 8'($urandom);
      y = 8'($urandom);
      m = model(o, x, y);
      send(o, x, y);
      wait_out(lat);
      hold = $urandom_range(0, 3);
      if (hold > 0) begin
        out_ready = 1'b0;
        repeat (hold) tick();
        chk("rnd_hold_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
      end
      chk("rnd_lat", 32'(lat),     (o == 3'd2) ? 32'd9 : 32'd1);
      chk("rnd_out", 32'(out),     32'(m.res));
      chk("rnd_err", 32'(out_err), 32'(m.err));
`ifdef ALU_FLAGS_EN
      chk("rnd_c", 32'(flag_c), 32'(m.c));
      chk("rnd_z", 32'(flag_z), 32'(m.z));
      chk("rnd_v", 32'(flag_v), 32'(m.v));
`endif
    end
    tick();
    chk("rnd_drain_valid", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
